seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Parametrised successor to the single-digit bicolour serial display driver.
- Receives display frames from the host MCU over a 3-wire serial link (sclk/sdata/slatch) and double-buffers each complete frame.
- Time-multiplexes NUM_DIGITS bicolour (red/green) 7-segment digits plus a discrete LED row, with a programmable brightness duty and frame-length checking.
- Sits between the MCU serial interface and the segment/digit drive pins.

Parameters:
- NUM_DIGITS, 4, number of bicolour digits scanned.
- NUM_LEDS, 7, discrete LEDs; must be 1..8.
- DWELL_LOG2, 6, log2 of clocks per scan slot; must be >= 4.
- SYNC_STAGES, 2, flip-flop stages per asynchronous serial input; must be >= 2.

Ports:
- clk  in  1  system clock (internal oscillator domain).
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  serial bit clock from MCU; asynchronous to clk.
- sdata  in  1  serial data; sampled on sclk rising edge.
- slatch  in  1  frame latch; asynchronous to clk.
- duty  in  4  brightness, 0 = 1/16 on, 15 = 16/16 on.
- blank  in  1  forces all drive outputs low.
- seg_red  out  7  red segment drive, active high.
- seg_grn  out  7  green segment drive, active high.
- dig_sel  out  NUM_DIGITS  one-hot digit common select, active high.
- led  out  NUM_LEDS  discrete LED drive, active high.
- frame_ok  out  1  one-clk pulse: valid frame accepted.
- frame_err  out  1  one-clk pulse: latch with wrong bit count; frame discarded.
- scan_sof  out  1  one-clk pulse at start of each scan cycle.

Behaviour:
- Reset (async, rst=1): all outputs 0; shift register, bit counter, pending and active display buffers cleared; scan at slot 0, sub-count 0.
- Serial input:
  - sclk, sdata and slatch each pass through SYNC_STAGES flops before use; rising edges are detected from the synchronised signals.
  - sdata is delayed to match sclk so sampling aligns with the sclk edge.
  - Minimum sclk high and low time: 2 clk periods.
- Shift register:
  - FRAME_BITS = 8 + 16*NUM_DIGITS.
  - On each sclk rise: shift left by one, sdata enters bit 0. The first bit sent ends up as the MSB.
  - bit_cnt increments and saturates at FRAME_BITS+1.
- Frame layout, MSB to LSB: {red[N-1], grn[N-1], ..., red[0], grn[0], led_byte}, 8 bits per byte.
  - Bit 7 of every segment byte is reserved and ignored.
  - led_byte bits above NUM_LEDS-1 are ignored.
- Latch (slatch rise):
  - If bit_cnt == FRAME_BITS: copy the frame into the pending buffer, set pending_valid, pulse frame_ok.
  - Otherwise: pulse frame_err and leave the pending buffer unchanged.
  - bit_cnt clears to 0 in both cases. The shift register contents are not cleared.
- Simultaneous sclk rise and slatch rise in the same clk: apply the shift first, then evaluate the latch using the incremented count.
- Buffer swap:
  - When pending_valid is set at a scan-cycle start (slot 0, sub-count 0), pending is copied to active and pending_valid clears.
  - The display never tears mid-scan.
  - A second accepted latch before the swap overwrites pending (last frame wins).
- Scan:
  - Slot counter k runs 0..2N+1, each slot lasting 2^DWELL_LOG2 clk.
  - Slot 2d: red phase of digit d. dig_sel = one-hot(d), seg_red = active red[d], seg_grn = 0, led = 0.
  - Slot 2d+1: green phase of digit d. seg_grn = active grn[d], seg_red = 0.
  - Slot 2N: LED slot. dig_sel = 0, led = active led_byte, segments 0.
  - Slot 2N+1: blank slot (dead time). All outputs 0.
  - After slot 2N+1, the counter wraps to slot 0.
  - Full scan period = (2N+2)*2^DWELL_LOG2 clk; with defaults, 640 clk.
- Duty:
  - In any slot, drive outputs are asserted only while sub-count[DWELL_LOG2-1 -: 4] <= duty.
  - With duty=15 the outputs are on for the whole slot.
  - duty is sampled at each slot start; a mid-slot change takes effect at the next slot.
- blank=1: all drive outputs are 0 from the next clk. Scanning, receive and swap continue unaffected.
- Outputs are registered, with one clk latency from the scan counter.
- dig_sel never has more than one bit set.
- scan_sof pulses in the first clk of slot 0.
- Reset asserted mid-frame or mid-scan: everything returns to reset values immediately, and any partial frame is lost.

Decomposition:
- Package seg_scan_pkg holds:
  - FRAME_BITS function.
  - Byte offset constants for red/grn/led fields.
  - Slot-type enum {SLOT_RED, SLOT_GRN, SLOT_LED, SLOT_BLANK}.
  - Slot-decode function (k → type, digit).
- Sub-module serial_frame_rx contains the synchronisers, edge detect, shift register, bit counter and latch/check logic. It outputs frame data, frame_ok and frame_err.
- The top level holds the pending/active buffers and the scan/duty logic.

Test Plan:
- Reset release: all outputs 0; first scan_sof at clk 1; dig_sel cycles 0001→0010→0100→1000 at 128-clk intervals (two slots per digit) with blank display (all buffers 0).
- Send 72-bit frame: digit0 red=0x3F, grn=0x06, other digits 0, led=0x55; latch → frame_ok pulse. After the next scan_sof: slot 0 seg_red=0x3F, slot 1 seg_grn=0x06, slot 8 led=0x55.
- Send 71 bits then latch → frame_err pulse, active display unchanged. Then send 72 bits → frame_ok.
- duty=3 → in every slot outputs are high for sub-counts 0..15 and low for 16..63. duty=15 → high for all 64 clk.
- Two valid frames (A then B) latched within one scan → only B is displayed after the next scan_sof. Also check that asserting blank mid-slot zeroes outputs the next clk and that a latch in the same clk as the last sclk rise is accepted.
- Assert rst mid-frame (after 40 bits) → outputs 0 immediately. A subsequent full 72-bit frame is accepted cleanly.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants, frame layout and slot decoding for the multiplexed
// bicolour segment scan driver.
package seg_scan_pkg;

  localparam int unsigned LED_BYTE_OFS = 0;
  localparam int unsigned GRN_BYTE_OFS = 8;
  localparam int unsigned RED_BYTE_OFS = 16;
  localparam int unsigned DIGIT_STRIDE = 16;

  typedef enum logic [1:0] {SLOT_RED, SLOT_GRN, SLOT_LED, SLOT_BLANK} slot_type_e;

  typedef struct packed {
    slot_type_e  kind;
    logic [15:0] digit;
  } slot_dec_t;

  function automatic int unsigned frame_bits(input int unsigned n);
    return 8 + 16 * n;
  endfunction

  function automatic slot_dec_t slot_decode(input int unsigned k, input int unsigned n);
    slot_dec_t d;
    d.digit = 16'(k >> 1);
    if (k < 2 * n)      d.kind = k[0] ? SLOT_GRN : SLOT_RED;
    else if (k == 2 * n) d.kind = SLOT_LED;
    else                d.kind = SLOT_BLANK;
    return d;
  endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// 3-wire serial frame receiver: input synchronisers, shift register,
// bit counting and frame-length check on latch.
module serial_frame_rx
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sclk,
  input  logic                                sdata,
  input  logic                                slatch,
  output logic [frame_bits(NUM_DIGITS)-1:0]   frame_data,
  output logic                                frame_ok,
  output logic                                frame_err
);

  localparam int unsigned FB = frame_bits(NUM_DIGITS);
  localparam int unsigned CW = $clog2(FB + 2);

  logic [SYNC_STAGES-1:0] sclk_sync, sdata_sync, slatch_sync;
  logic                   sclk_q, slatch_q;
  logic                   sclk_s, sdata_s, slatch_s;
  logic                   sclk_rise, latch_rise;
  logic [FB-1:0]          shreg, shreg_nxt;
  logic [CW-1:0]          bit_cnt, cnt_nxt;

  // sdata runs through the same depth as sclk so the sampled bit lines up
  // with the detected sclk edge.
  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign sdata_s    = sdata_sync[SYNC_STAGES-1];
  assign slatch_s   = slatch_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_q;
  assign latch_rise = slatch_s & ~slatch_q;

  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    if (sclk_rise) begin
      shreg_nxt = {shreg[FB-2:0], sdata_s};
      if (bit_cnt != CW'(FB + 1)) cnt_nxt = bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync   <= '0;
      sdata_sync  <= '0;
      slatch_sync <= '0;
      sclk_q      <= 1'b0;
      slatch_q    <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdata_sync  <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      slatch_sync <= {slatch_sync[SYNC_STAGES-2:0], slatch};
      sclk_q      <= sclk_s;
      slatch_q    <= slatch_s;
      shreg       <= shreg_nxt;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      if (latch_rise) begin
        bit_cnt <= '0;
        if (cnt_nxt == CW'(FB)) frame_ok  <= 1'b1;
        else                    frame_err <= 1'b1;
      end else begin
        bit_cnt <= cnt_nxt;
      end
    end
  end

  // While frame_ok is high the shift register still holds exactly the
  // accepted frame (including a shift that coincided with the latch).
  assign frame_data = shreg;

endmodule

// File: rtl/seg_scan_driver.sv
// Double-buffered, time-multiplexed bicolour 7-segment + LED row driver
// fed by a 3-wire serial frame link.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned NUM_LEDS    = 7,
  parameter int unsigned DWELL_LOG2  = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  sdata,
  input  logic                  slatch,
  input  logic [3:0]            duty,
  input  logic                  blank,
  output logic [6:0]            seg_red,
  output logic [6:0]            seg_grn,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic                  scan_sof
);

  localparam int unsigned FB    = frame_bits(NUM_DIGITS);
  localparam int unsigned NSLOT = 2 * NUM_DIGITS + 2;
  localparam int unsigned SW    = $clog2(NSLOT);
  localparam int unsigned DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [FB-1:0]         rx_data, pending, active, active_view;
  logic                  pending_valid;
  logic [SW-1:0]         slot;
  logic [DWELL_LOG2-1:0] sub;
  logic [3:0]            duty_q, duty_eff;
  logic                  scan_start, swap, duty_on;
  slot_dec_t             dec;
  logic [DW-1:0]         dig_idx;
  logic [6:0]            red_b [NUM_DIGITS];
  logic [6:0]            grn_b [NUM_DIGITS];
  logic [6:0]            red_n, grn_n;
  logic [NUM_DIGITS-1:0] dig_n;
  logic [NUM_LEDS-1:0]   led_n;

  serial_frame_rx #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .sdata      (sdata),
    .slatch     (slatch),
    .frame_data (rx_data),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err)
  );

  assign scan_start = (slot == '0) && (sub == '0);
  assign swap       = scan_start & pending_valid;
  // Decode from the buffer being swapped in so the first clk of a scan
  // already shows the new frame.
  assign active_view = swap ? pending : active;
  assign duty_eff    = (sub == '0) ? duty : duty_q;
  assign duty_on     = sub[DWELL_LOG2-1 -: 4] <= duty_eff;
  assign dec         = slot_decode(32'(slot), NUM_DIGITS);
  assign dig_idx     = DW'(dec.digit);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_bytes
    assign red_b[g] = active_view[RED_BYTE_OFS + DIGIT_STRIDE * g +: 7];
    assign grn_b[g] = active_view[GRN_BYTE_OFS + DIGIT_STRIDE * g +: 7];
  end

  always_comb begin
    red_n = '0;
    grn_n = '0;
    dig_n = '0;
    led_n = '0;
    if (duty_on && !blank) begin
      case (dec.kind)
        SLOT_RED: begin
          dig_n = NUM_DIGITS'(1) << dig_idx;
          red_n = red_b[dig_idx];
        end
        SLOT_GRN: begin
          dig_n = NUM_DIGITS'(1) << dig_idx;
          grn_n = grn_b[dig_idx];
        end
        SLOT_LED: led_n = active_view[LED_BYTE_OFS +: NUM_LEDS];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending       <= '0;
      active        <= '0;
      pending_valid <= 1'b0;
      slot          <= '0;
      sub           <= '0;
      duty_q        <= '0;
      seg_red       <= '0;
      seg_grn       <= '0;
      dig_sel       <= '0;
      led           <= '0;
      scan_sof      <= 1'b0;
    end else begin
      if (frame_ok) begin
        pending       <= rx_data;
        pending_valid <= 1'b1;
      end else if (swap) begin
        pending_valid <= 1'b0;
      end
      if (swap) active <= pending;
      sub    <= sub + DWELL_LOG2'(1);
      duty_q <= duty_eff;
      if (sub == '1) slot <= (slot == SW'(NSLOT - 1)) ? '0 : slot + SW'(1);
      seg_red  <= red_n;
      seg_grn  <= grn_n;
      dig_sel  <= dig_n;
      led      <= led_n;
      scan_sof <= scan_start;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (default parameters).
`timescale 1ns/1ps
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst, sclk, sdata, slatch, blank;
  logic [3:0] duty;
  logic [6:0] seg_red, seg_grn;
  logic [3:0] dig_sel;
  logic [6:0] led;
  logic       frame_ok, frame_err, scan_sof;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int ok0, err0;

  logic [71:0] fa, fa2, fb, fc, fd;

  seg_scan_driver #(
    .NUM_DIGITS  (4),
    .NUM_LEDS    (7),
    .DWELL_LOG2  (6),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .sdata     (sdata),
    .slatch    (slatch),
    .duty      (duty),
    .blank     (blank),
    .seg_red   (seg_red),
    .seg_grn   (seg_grn),
    .dig_sel   (dig_sel),
    .led       (led),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .scan_sof  (scan_sof)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_ok)  ok_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic wait_sof();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_sof && n < 700);
    cyc = 0;
    chk("sof_seen", 32'(scan_sof), 32'h1);
  endtask

  task automatic do_latch();
    slatch = 1'b1;
    step(3);
    slatch = 1'b0;
    step(4);
  endtask

  // Sends the top nbits of f, MSB first; simul raises slatch together
  // with the final sclk rise.
  task automatic send(input logic [71:0] f, input int nbits, input int half, input bit simul);
    for (int i = 71; i > 71 - nbits; i--) begin
      sdata = f[i];
      sclk  = 1'b0;
      step(half);
      sclk = 1'b1;
      if (simul && i == 72 - nbits) slatch = 1'b1;
      step(half);
    end
    sclk   = 1'b0;
    slatch = 1'b0;
    step(4);
  endtask

  initial begin
    fa  = {48'h0, 8'h3F, 8'h06, 8'h55};
    fa2 = {48'h0, 8'h11, 8'h00, 8'h00};
    fb  = {48'h0, 8'h22, 8'h33, 8'h0F};
    fc  = {8'h81, 8'hFF, 48'h0, 8'hFF};
    fd  = {48'h0, 8'h7E, 8'h00, 8'h01};
    rst = 1'b1; sclk = 1'b0; sdata = 1'b0; slatch = 1'b0; blank = 1'b0; duty = 4'd15;

    // Reset state
    step(3);
    chk("rst_red", 32'(seg_red), 32'h0);
    chk("rst_grn", 32'(seg_grn), 32'h0);
    chk("rst_dig", 32'(dig_sel), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_sof", 32'(scan_sof), 32'h0);
    chk("rst_ok_err", 32'({frame_ok, frame_err}), 32'h0);

    // Scan sequence with empty buffers
    rst = 1'b0;
    step(1);
    cyc = 0;
    chk("sof_clk1", 32'(scan_sof), 32'h1);
    chk("dig_s0", 32'(dig_sel), 32'h1);
    goto(1);   chk("sof_c1", 32'(scan_sof), 32'h0);
    goto(64);  chk("dig_s1", 32'(dig_sel), 32'h1);
    goto(128); chk("dig_s2", 32'(dig_sel), 32'h2);
    goto(256); chk("dig_s4", 32'(dig_sel), 32'h4);
    goto(384); chk("dig_s6", 32'(dig_sel), 32'h8);
    chk("red_empty", 32'(seg_red), 32'h0);
    goto(512); chk("dig_led", 32'(dig_sel), 32'h0);
    goto(576); chk("dig_blank", 32'(dig_sel), 32'h0);
    goto(639); chk("sof_c639", 32'(scan_sof), 32'h0);
    goto(640); chk("sof_c640", 32'(scan_sof), 32'h1);

    // Frame A
    ok0 = ok_cnt; err0 = err_cnt;
    send(fa, 72, 3, 1'b0);
    do_latch();
    chk("a_ok", 32'(ok_cnt - ok0), 32'h1);
    chk("a_err", 32'(err_cnt - err0), 32'h0);
    wait_sof();
    chk("a_red0", 32'(seg_red), 32'h3F);
    chk("a_grn0", 32'(seg_grn), 32'h0);
    chk("a_dig0", 32'(dig_sel), 32'h1);
    goto(63);  chk("a_red63", 32'(seg_red), 32'h3F);
    goto(64);  chk("a_grn64", 32'(seg_grn), 32'h06);
    chk("a_red64", 32'(seg_red), 32'h0);
    goto(512); chk("a_led", 32'(led), 32'h55);
    goto(576); chk("a_led_blank", 32'(led), 32'h0);

    // Short frame rejected, then frame C accepted
    ok0 = ok_cnt; err0 = err_cnt;
    send(fa2, 71, 3, 1'b0);
    do_latch();
    chk("short_err", 32'(err_cnt - err0), 32'h1);
    chk("short_ok", 32'(ok_cnt - ok0), 32'h0);
    wait_sof();
    chk("short_keep", 32'(seg_red), 32'h3F);
    ok0 = ok_cnt;
    send(fc, 72, 3, 1'b0);
    do_latch();
    chk("c_ok", 32'(ok_cnt - ok0), 32'h1);
    wait_sof();
    chk("c_red0", 32'(seg_red), 32'h0);
    goto(384); chk("c_dig6", 32'(dig_sel), 32'h8);
    chk("c_red3", 32'(seg_red), 32'h01);
    goto(448); chk("c_grn3", 32'(seg_grn), 32'h7F);
    goto(512); chk("c_led", 32'(led), 32'h7F);

    // Duty 3: on for sub-counts 0..15
    duty = 4'd3;
    wait_sof();
    goto(15);  chk("d3_on15", 32'(dig_sel), 32'h1);
    goto(16);  chk("d3_off16", 32'(dig_sel), 32'h0);
    goto(399); chk("d3_red_on", 32'(seg_red), 32'h01);
    goto(400); chk("d3_red_off", 32'(seg_red), 32'h0);
    goto(527); chk("d3_led_on", 32'(led), 32'h7F);
    goto(528); chk("d3_led_off", 32'(led), 32'h0);
    goto(600); duty = 4'd15;
    wait_sof();
    goto(63);  chk("d15_c63", 32'(dig_sel), 32'h1);
    goto(400); chk("d15_c400", 32'(seg_red), 32'h01);
    duty = 4'd0;
    goto(430); chk("duty_midslot", 32'(seg_red), 32'h01);
    goto(451); chk("d0_sub3", 32'(seg_grn), 32'h7F);
    goto(452); chk("d0_sub4", 32'(seg_grn), 32'h0);
    duty = 4'd15;

    // A then B within one scan; B latched with its last sclk rise
    wait_sof();
    ok0 = ok_cnt; err0 = err_cnt;
    send(fa2, 72, 2, 1'b0);
    do_latch();
    send(fb, 72, 2, 1'b1);
    chk("ab_ok", 32'(ok_cnt - ok0), 32'h2);
    chk("ab_err", 32'(err_cnt - err0), 32'h0);
    chk("ab_in_scan", 32'(cyc < 630), 32'h1);
    wait_sof();
    chk("b_red0", 32'(seg_red), 32'h22);
    goto(10);  chk("b_preblank", 32'(seg_red), 32'h22);
    blank = 1'b1;
    goto(11);  chk("blank_red", 32'(seg_red), 32'h0);
    chk("blank_dig", 32'(dig_sel), 32'h0);
    blank = 1'b0;
    goto(13);  chk("unblank_red", 32'(seg_red), 32'h22);
    goto(64);  chk("b_grn0", 32'(seg_grn), 32'h33);
    goto(512); chk("b_led", 32'(led), 32'h0F);

    // Reset in the middle of a frame
    wait_sof();
    goto(5);
    ok0 = ok_cnt; err0 = err_cnt;
    send(fd, 40, 2, 1'b0);
    chk("pre_rst_dig", 32'(dig_sel), 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_dig", 32'(dig_sel), 32'h0);
    chk("mid_rst_segs", 32'({seg_red, seg_grn, led}), 32'h0);
    step(2);
    rst = 1'b0;
    wait_sof();
    chk("post_rst_red", 32'(seg_red), 32'h0);
    send(fd, 72, 3, 1'b0);
    do_latch();
    chk("d_ok", 32'(ok_cnt - ok0), 32'h1);
    chk("d_err", 32'(err_cnt - err0), 32'h0);
    wait_sof();
    chk("d_red0", 32'(seg_red), 32'h7E);
    goto(512); chk("d_led", 32'(led), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
